// File: rtl/serial_subtractor_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

    // Control states of the subtractor sequencer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: enough to hold WIDTH-1, but never narrower than one bit.
    function automatic int cnt_w(input int width);
        int w;
        w = $clog2(width);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = x - y - bin, bout = borrow out.
module full_subtractor
    import serial_sub_pkg::*;
(
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    // NOTE: continuous assigns fully define both outputs, so no storage can be inferred.
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~x & bin) | (y & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, LSB first, one bit per clock,
// with a valid/ready handshake on both the operand and the result side.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int             CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_diff_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_q;
    logic             r_borrow;
    logic             r_out_valid;
    logic [CW-1:0]    r_cnt;

    logic             w_d;
    logic             w_bo;
    logic [WIDTH-1:0] w_diff_next;

    // The one arithmetic cell, fed from the LSBs of the operand shifters.
    full_subtractor u_fs (
        .x    (r_a_sr[0]),
        .y    (r_b_sr[0]),
        .bin  (r_borrow_q),
        .d    (w_d),
        .bout (w_bo)
    );

    // New difference bit enters at the MSB end; after WIDTH shifts the LSB has
    // arrived at bit 0. Written as a shift so WIDTH=1 needs no special case.
    assign w_diff_next = (r_diff_sr >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

    // Gate with rst so the producer never sees ready while the block is held in reset.
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
    assign borrow    = r_borrow;

    // Sequencer: accept operands, shift WIDTH bits through the cell, hold result until taken.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state     <= IDLE;
            r_a_sr      <= '0;
            r_b_sr      <= '0;
            r_diff_sr   <= '0;
            r_diff      <= '0;
            r_borrow_q  <= 1'b0;
            r_borrow    <= 1'b0;
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a_sr     <= a;
                        r_b_sr     <= b;
                        r_borrow_q <= bin;
                        r_diff_sr  <= '0;
                        r_cnt      <= '0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    r_a_sr     <= r_a_sr >> 1;
                    r_b_sr     <= r_b_sr >> 1;
                    r_diff_sr  <= w_diff_next;
                    r_borrow_q <= w_bo;
                    r_cnt      <= r_cnt + 1'b1;
                    if (r_cnt == LAST_BIT) begin
                        r_diff      <= w_diff_next;
                        r_borrow    <= w_bo;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    // Result stays frozen until the consumer takes it; new operands are ignored.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH = 4, 8 and 1.
module tb_serial_subtractor;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       d4_in_valid, d4_in_ready, d4_bin, d4_out_valid, d4_out_ready, d4_borrow;
    logic [3:0] d4_a, d4_b, d4_diff;
    // WIDTH=8 instance
    logic       d8_in_valid, d8_in_ready, d8_bin, d8_out_valid, d8_out_ready, d8_borrow;
    logic [7:0] d8_a, d8_b, d8_diff;
    // WIDTH=1 instance
    logic       d1_in_valid, d1_in_ready, d1_bin, d1_out_valid, d1_out_ready, d1_borrow;
    logic [0:0] d1_a, d1_b, d1_diff;

    serial_subtractor #(.WIDTH(4)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready),
        .a(d4_a), .b(d4_b), .bin(d4_bin), .out_valid(d4_out_valid),
        .out_ready(d4_out_ready), .diff(d4_diff), .borrow(d4_borrow)
    );
    serial_subtractor #(.WIDTH(8)) u_d8 (
        .clk(clk), .rst(rst), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .bin(d8_bin), .out_valid(d8_out_valid),
        .out_ready(d8_out_ready), .diff(d8_diff), .borrow(d8_borrow)
    );
    serial_subtractor #(.WIDTH(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .bin(d1_bin), .out_valid(d1_out_valid),
        .out_ready(d1_out_ready), .diff(d1_diff), .borrow(d1_borrow)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int sel, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic bi);
        case (sel)
            4:       begin d4_in_valid = v; d4_a = a[3:0]; d4_b = b[3:0]; d4_bin = bi; end
            8:       begin d8_in_valid = v; d8_a = a[7:0]; d8_b = b[7:0]; d8_bin = bi; end
            default: begin d1_in_valid = v; d1_a = a[0:0]; d1_b = b[0:0]; d1_bin = bi; end
        endcase
    endtask

    task automatic set_or(input int sel, input logic v);
        case (sel)
            4:       d4_out_ready = v;
            8:       d8_out_ready = v;
            default: d1_out_ready = v;
        endcase
    endtask

    function automatic logic get_ov(input int sel);
        case (sel)
            4:       return d4_out_valid;
            8:       return d8_out_valid;
            default: return d1_out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int sel);
        case (sel)
            4:       return d4_in_ready;
            8:       return d8_in_ready;
            default: return d1_in_ready;
        endcase
    endfunction

    function automatic logic [31:0] get_diff(input int sel);
        case (sel)
            4:       return {28'd0, d4_diff};
            8:       return {24'd0, d8_diff};
            default: return {31'd0, d1_diff};
        endcase
    endfunction

    function automatic logic get_bo(input int sel);
        case (sel)
            4:       return d4_borrow;
            8:       return d8_borrow;
            default: return d1_borrow;
        endcase
    endfunction

    // One complete operation: accept, count latency, check result, hand it off.
    task automatic run_op(input int sel, input int w, input logic [31:0] a, input logic [31:0] b,
                          input logic bi, input logic [31:0] exp_d, input logic exp_b,
                          input string tag);
        int lat;
        set_or(sel, 1'b0);
        set_in(sel, 1'b1, a, b, bi);
        check({tag, "_in_ready"}, 32'(get_ir(sel)), 32'd1);
        step();
        // Operands change after the accept edge; the result must not follow them.
        set_in(sel, 1'b0, ~a, ~b, ~bi);
        lat = 0;
        while (!get_ov(sel) && lat < 64) begin
            step();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(w));
        check({tag, "_diff"}, get_diff(sel), exp_d);
        check({tag, "_borrow"}, 32'(get_bo(sel)), 32'(exp_b));
        set_or(sel, 1'b1);
        step();
        check({tag, "_ov_drop"}, 32'(get_ov(sel)), 32'd0);
        check({tag, "_ready_back"}, 32'(get_ir(sel)), 32'd1);
        set_or(sel, 1'b0);
    endtask

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation timed out");
    end

    initial begin
        logic        seen_ov;
        logic [4:0]  exp_q[$];
        logic [4:0]  exp_v;
        logic [3:0]  ra, rb;
        logic        rbi, acc, ovr;
        int          sent, got, cycles;

        rst = 1'b1;
        set_in(4, 1'b0, 0, 0, 1'b0); set_or(4, 1'b0);
        set_in(8, 1'b0, 0, 0, 1'b0); set_or(8, 1'b0);
        set_in(1, 1'b0, 0, 0, 1'b0); set_or(1, 1'b0);
        step();
        step();

        // Reset state
        check("rst_in_ready", 32'(d4_in_ready), 32'd0);
        check("rst_out_valid", 32'(d4_out_valid), 32'd0);
        check("rst_diff", {28'd0, d4_diff}, 32'd0);
        check("rst_borrow", 32'(d4_borrow), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(d4_in_ready), 32'd1);
        step();

        // Basic operations at WIDTH=4
        run_op(4, 4, 9, 3, 1'b0, 32'h6, 1'b0, "w4_9m3");
        run_op(4, 4, 3, 9, 1'b0, 32'hA, 1'b1, "w4_3m9");
        run_op(4, 4, 0, 0, 1'b1, 32'hF, 1'b1, "w4_0m0b1");

        // Backpressure: 7 - 2 = 5 held in DONE for 5 cycles with in_valid pulses
        set_in(4, 1'b1, 7, 2, 1'b0);
        step();
        set_in(4, 1'b0, 0, 0, 1'b0);
        repeat (4) step();
        check("bp_ov_initial", 32'(d4_out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            set_in(4, (i % 2) == 0, 15, 1, 1'b1);
            step();
            check("bp_ov_held", 32'(d4_out_valid), 32'd1);
            check("bp_in_ready_low", 32'(d4_in_ready), 32'd0);
            check("bp_diff_stable", {28'd0, d4_diff}, 32'h5);
            check("bp_borrow_stable", 32'(d4_borrow), 32'd0);
        end
        set_in(4, 1'b0, 0, 0, 1'b0);
        set_or(4, 1'b1);
        step();
        check("bp_release_ov", 32'(d4_out_valid), 32'd0);
        check("bp_release_ready", 32'(d4_in_ready), 32'd1);
        set_or(4, 1'b0);

        // Mid-operation reset at RUN bit 2
        set_in(4, 1'b1, 9, 3, 1'b0);
        set_or(4, 1'b1);
        step();
        set_in(4, 1'b0, 0, 0, 1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_ov", 32'(d4_out_valid), 32'd0);
        check("midrst_diff", {28'd0, d4_diff}, 32'd0);
        check("midrst_borrow", 32'(d4_borrow), 32'd0);
        check("midrst_in_ready", 32'(d4_in_ready), 32'd0);
        rst = 1'b0;
        seen_ov = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            seen_ov = seen_ov | d4_out_valid;
        end
        check("midrst_no_result", 32'(seen_ov), 32'd0);
        set_or(4, 1'b0);
        run_op(4, 4, 5, 5, 1'b0, 32'h0, 1'b0, "w4_5m5");

        // Other widths
        run_op(8, 8, 32'h00, 32'hFF, 1'b0, 32'h01, 1'b1, "w8_0mff");
        run_op(1, 1, 0, 1, 1'b0, 32'h1, 1'b1, "w1_0m1");

        // Random back-to-back traffic with random consumer backpressure
        sent = 0;
        got = 0;
        cycles = 0;
        ra = 4'($urandom); rb = 4'($urandom); rbi = 1'($urandom);
        set_in(4, 1'b1, {28'd0, ra}, {28'd0, rb}, rbi);
        while (got < 1000 && cycles < 40000) begin
            set_or(4, 1'($urandom_range(0, 1)));
            acc = d4_in_valid && d4_in_ready;
            ovr = d4_out_valid && d4_out_ready;
            if (ovr) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected", {27'd0, d4_borrow, d4_diff}, 32'h0);
                end else begin
                    exp_v = exp_q.pop_front();
                    check("rand_result", {27'd0, d4_borrow, d4_diff}, {27'd0, exp_v});
                end
                got++;
            end
            if (acc) exp_q.push_back(5'({1'b0, ra} - {1'b0, rb} - {4'd0, rbi}));
            step();
            if (acc) begin
                sent++;
                if (sent < 1000) begin
                    ra = 4'($urandom); rb = 4'($urandom); rbi = 1'($urandom);
                    set_in(4, 1'b1, {28'd0, ra}, {28'd0, rb}, rbi);
                end else begin
                    set_in(4, 1'b0, 0, 0, 1'b0);
                end
            end
            cycles++;
        end
        check("rand_count", 32'(got), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
